// File: rtl/wb_adder_accel.sv
// Wishbone-slave 32-bit adder accelerator: firmware loads OPA/OPB, pulses START,
// and the sum is built CHUNK bits per cycle with a rippling carry register.
module wb_adder_accel #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          CHUNK     = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        irq_o
);

    localparam int N     = 32 / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [5:0] OFF_CTRL   = 6'h00;
    localparam logic [5:0] OFF_STATUS = 6'h01;
    localparam logic [5:0] OFF_OPA    = 6'h02;
    localparam logic [5:0] OFF_OPB    = 6'h03;
    localparam logic [5:0] OFF_RESULT = 6'h04;

    logic [0:0]       state;
    logic [IDX_W-1:0] idx;
    logic [31:0]      opa;
    logic [31:0]      opb;
    logic [31:0]      result;
    logic             c_acc;
    logic             carry;
    logic             done;
    logic             irq_en;

    logic             in_win;
    logic             accept;
    logic             wr;
    logic             idle;
    logic [5:0]       offset;
    logic [31:0]      rd_data;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic             unused_adr;

    assign unused_adr = ^wbs_adr_i[1:0];

    // Ack gating on !wbs_ack_o makes every access exactly one cycle and
    // forces one idle cycle between back-to-back requests.
    assign in_win = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign accept = wbs_stb_i & wbs_cyc_i & in_win & ~wbs_ack_o;
    assign wr     = accept & wbs_we_i;
    assign offset = wbs_adr_i[7:2];
    assign idle   = (state == S_IDLE);
    assign irq_o  = done & irq_en;

    always_comb begin
        rd_data = 32'h0;
        case (offset)
            OFF_CTRL:   rd_data = {30'h0, irq_en, 1'b0};
            OFF_STATUS: rd_data = {29'h0, carry, done, ~idle};
            OFF_OPA:    rd_data = opa;
            OFF_OPB:    rd_data = opb;
            OFF_RESULT: rd_data = result;
            default:    rd_data = 32'h0;
        endcase
    end

    always_comb begin
        a_chunk   = opa[idx*CHUNK +: CHUNK];
        b_chunk   = opb[idx*CHUNK +: CHUNK];
        chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, c_acc};
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= S_IDLE;
            idx       <= '0;
            opa       <= 32'h0;
            opb       <= 32'h0;
            result    <= 32'h0;
            c_acc     <= 1'b0;
            carry     <= 1'b0;
            done      <= 1'b0;
            irq_en    <= 1'b0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'h0;
        end else begin
            wbs_ack_o <= accept;
            wbs_dat_o <= accept ? rd_data : 32'h0;

            if (wr) begin
                case (offset)
                    OFF_CTRL: begin
                        if (wbs_sel_i[0]) begin
                            irq_en <= wbs_dat_i[1];
                            if (wbs_dat_i[0] && idle) begin
                                state <= S_RUN;
                                idx   <= '0;
                                c_acc <= 1'b0;
                                done  <= 1'b0;
                                carry <= 1'b0;
                            end
                        end
                    end
                    OFF_STATUS: begin
                        if (wbs_sel_i[0] && wbs_dat_i[1]) done <= 1'b0;
                    end
                    OFF_OPA: begin
                        if (idle) begin
                            for (int b = 0; b < 4; b++)
                                if (wbs_sel_i[b]) opa[b*8 +: 8] <= wbs_dat_i[b*8 +: 8];
                        end
                    end
                    OFF_OPB: begin
                        if (idle) begin
                            for (int b = 0; b < 4; b++)
                                if (wbs_sel_i[b]) opb[b*8 +: 8] <= wbs_dat_i[b*8 +: 8];
                        end
                    end
                    default: ;
                endcase
            end

            // Placed after the register writes so a DONE set beats a same-edge clear.
            if (state == S_RUN) begin
                result[idx*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
                c_acc <= chunk_sum[CHUNK];
                if (idx == LAST_IDX) begin
                    state <= S_IDLE;
                    idx   <= '0;
                    done  <= 1'b1;
                    carry <= chunk_sum[CHUNK];
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_adder_accel.sv
// Directed bench for wb_adder_accel: register access, chunked add latency,
// carry, byte lanes, busy protection, interrupt, decode and mid-run reset.
module tb_wb_adder_accel;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] dat_o;
    logic        irq;

    int total = 0;
    int bad   = 0;

    wb_adder_accel #(.BASE_ADDR(BASE), .CHUNK(8)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_o),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One bus access; gives up after 10 cycles without an ack.
    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rdat, output logic acked);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
        acked = 1'b0;
        rdat  = 32'h0;
        for (int i = 0; i < 10 && !acked; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                acked = 1'b1;
                rdat  = dat_o;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        logic        k;
        bus(1'b1, BASE + off, d, s, r, k);
        check("wr_ack", {31'h0, k}, 32'h1);
    endtask

    task automatic rd(input string tag, input logic [31:0] off, input logic [31:0] exp);
        logic [31:0] r;
        logic        k;
        bus(1'b0, BASE + off, 32'h0, 4'hF, r, k);
        check({tag, "_ack"}, {31'h0, k}, 32'h1);
        check(tag, r, exp);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    initial begin
        int cycles;
        logic [31:0] r;
        logic        k;

        stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; wdat = 32'h0;
        rst = 1'b1;
        wait_cycles(2);
        check("rst_ack", {31'h0, ack}, 32'h0);
        check("rst_dat", dat_o, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        @(negedge clk); rst = 1'b0;
        rd("rst_status", 32'h04, 32'h0);
        rd("rst_result", 32'h10, 32'h0);
        rd("rst_opa", 32'h08, 32'h0);

        // Basic add with IRQ_EN set in the same START write; irq tracks DONE.
        wr(32'h08, 32'h0000_1234, 4'hF);
        wr(32'h0C, 32'h0000_4321, 4'hF);
        wr(32'h00, 32'h0000_0003, 4'hF);
        check("start_irq_low", {31'h0, irq}, 32'h0);
        cycles = 0;
        while (!irq && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
        check("latency", cycles, 4);
        rd("add_result", 32'h10, 32'h0000_5555);
        rd("add_status", 32'h04, 32'h2);
        rd("add_ctrl", 32'h00, 32'h2);
        wr(32'h04, 32'h2, 4'hF);
        check("w1c_irq", {31'h0, irq}, 32'h0);
        rd("w1c_status", 32'h04, 32'h0);

        // Carry ripples through every chunk; IRQ_EN dropped by this write.
        wr(32'h08, 32'hFFFF_FFFF, 4'hF);
        wr(32'h0C, 32'h0000_0001, 4'hF);
        wr(32'h00, 32'h0000_0001, 4'hF);
        wait_cycles(6);
        rd("carry_status", 32'h04, 32'h6);
        rd("carry_result", 32'h10, 32'h0);
        check("carry_irq_off", {31'h0, irq}, 32'h0);

        // Byte lanes.
        wr(32'h08, 32'h0, 4'hF);
        wr(32'h08, 32'hAABB_CCDD, 4'b0101);
        rd("lanes_opa", 32'h08, 32'h00BB_00DD);

        // Writes to OPA and START during RUN are ignored.
        wr(32'h08, 32'h1, 4'hF);
        wr(32'h0C, 32'h1, 4'hF);
        wr(32'h00, 32'h3, 4'hF);
        wr(32'h08, 32'hFFFF_FFFF, 4'hF);
        wr(32'h00, 32'h3, 4'hF);
        wait_cycles(6);
        check("busy_irq", {31'h0, irq}, 32'h1);
        rd("busy_result", 32'h10, 32'h2);
        rd("busy_opa", 32'h08, 32'h1);
        rd("busy_status", 32'h04, 32'h2);
        wait_cycles(6);
        rd("single_done", 32'h04, 32'h2);
        wr(32'h04, 32'h2, 4'hF);
        check("busy_w1c_irq", {31'h0, irq}, 32'h0);

        // Decode.
        rd("hole_read", 32'h14, 32'h0);
        bus(1'b0, BASE + 32'h100, 32'h0, 4'hF, r, k);
        check("out_of_window_ack", {31'h0, k}, 32'h0);

        // Reset in the middle of a run.
        wr(32'h08, 32'h5, 4'hF);
        wr(32'h0C, 32'h6, 4'hF);
        wr(32'h00, 32'h3, 4'hF);
        @(negedge clk); rst = 1'b1;
        wait_cycles(2);
        check("midrst_ack", {31'h0, ack}, 32'h0);
        check("midrst_dat", dat_o, 32'h0);
        check("midrst_irq", {31'h0, irq}, 32'h0);
        @(negedge clk); rst = 1'b0;
        wait_cycles(6);
        check("midrst_irq_after", {31'h0, irq}, 32'h0);
        rd("midrst_status", 32'h04, 32'h0);
        rd("midrst_result", 32'h10, 32'h0);
        rd("midrst_opa", 32'h08, 32'h0);
        rd("midrst_ctrl", 32'h00, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
